// File: rtl/scnn_pe_v2_if.sv
// Job handshake, compressed operand buses and result bus for the sparse conv PE.
interface scnn_pe_v2_if #(
    parameter int PARAM_MAX_NZI = 16,
    parameter int PARAM_MAX_NZW = 16,
    parameter int PARAM_IDIM    = 4,
    parameter int PARAM_WDIM    = 3,
    parameter int PARAM_ACC_W   = 32
);
    localparam int ODIM = PARAM_IDIM - PARAM_WDIM + 1;

    logic                          start;
    logic                          clear_acc;
    logic [7:0]                    num_nz_ips;
    logic [7:0]                    num_nz_wts;
    logic signed [15:0]            compressed_inputs  [PARAM_MAX_NZI];
    logic [7:0]                    comp_indices_ips   [PARAM_MAX_NZI];
    logic signed [15:0]            compressed_weights [PARAM_MAX_NZW];
    logic [7:0]                    comp_indices_wts   [PARAM_MAX_NZW];
    logic                          busy;
    logic                          done;
    logic signed [PARAM_ACC_W-1:0] conv_outputs [ODIM*ODIM];

    modport master (
        output start, clear_acc, num_nz_ips, num_nz_wts,
        output compressed_inputs, comp_indices_ips, compressed_weights, comp_indices_wts,
        input  busy, done, conv_outputs
    );

    modport slave (
        input  start, clear_acc, num_nz_ips, num_nz_wts,
        input  compressed_inputs, comp_indices_ips, compressed_weights, comp_indices_wts,
        output busy, done, conv_outputs
    );
endinterface

// File: rtl/scnn_pe_v2.sv
// Sparse CNN processing element: I x F cartesian-product multiplier array with
// scatter-add into an ODIM x ODIM accumulator plane (valid convolution).
module scnn_pe_v2 #(
    parameter int PARAM_I       = 4,
    parameter int PARAM_F       = 4,
    parameter int PARAM_MAX_NZI = 16,
    parameter int PARAM_MAX_NZW = 16,
    parameter int PARAM_IDIM    = 4,
    parameter int PARAM_WDIM    = 3,
    parameter int PARAM_ACC_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    scnn_pe_v2_if.slave   bus
);
    localparam int ODIM   = PARAM_IDIM - PARAM_WDIM + 1;
    localparam int NOUT   = ODIM * ODIM;
    localparam int NPROD  = PARAM_I * PARAM_F;
    localparam int NZI_IW = (PARAM_MAX_NZI > 1) ? $clog2(PARAM_MAX_NZI) : 1;
    localparam int NZW_IW = (PARAM_MAX_NZW > 1) ? $clog2(PARAM_MAX_NZW) : 1;
    localparam int OUT_IW = (NOUT > 1) ? $clog2(NOUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state;
    logic       busy_r;
    logic       done_r;
    logic [7:0] cnt_ips;
    logic [7:0] cnt_wts;
    logic [7:0] grp_i;
    logic [7:0] grp_w;
    logic [7:0] n_grp_i;
    logic [7:0] n_grp_w;
    logic       vld_p0;
    logic       vld_p1;

    logic signed [15:0]            ip_val_p0 [PARAM_I];
    logic [7:0]                    ip_idx_p0 [PARAM_I];
    logic                          ip_ok_p0  [PARAM_I];
    logic signed [15:0]            wt_val_p0 [PARAM_F];
    logic [7:0]                    wt_idx_p0 [PARAM_F];
    logic                          wt_ok_p0  [PARAM_F];
    logic signed [31:0]            prod_p1   [NPROD];
    logic [OUT_IW-1:0]             oidx_p1   [NPROD];
    logic                          ok_p1     [NPROD];
    logic signed [PARAM_ACC_W-1:0] acc       [NOUT];
    logic signed [PARAM_ACC_W-1:0] grp_sum   [NOUT];

    function automatic logic [7:0] clamp_cnt(input logic [7:0] n, input int max_n);
        return (int'(n) > max_n) ? 8'(max_n) : n;
    endfunction

    function automatic logic [7:0] num_groups(input logic [7:0] n, input int lanes);
        return 8'((int'(n) + lanes - 1) / lanes);
    endfunction

    function automatic logic [NZI_IW-1:0] ips_slot(input logic [7:0] grp, input int lane);
        int p;
        p = int'(grp) * PARAM_I + lane;
        return (p < PARAM_MAX_NZI) ? NZI_IW'(p) : '0;
    endfunction

    function automatic logic [NZW_IW-1:0] wts_slot(input logic [7:0] grp, input int lane);
        int p;
        p = int'(grp) * PARAM_F + lane;
        return (p < PARAM_MAX_NZW) ? NZW_IW'(p) : '0;
    endfunction

    // Output row = input row - kernel row, output col = input col - kernel col.
    function automatic logic out_hit(input logic [7:0] ii, input logic [7:0] wi);
        int oy;
        int ox;
        oy = int'(ii) / PARAM_IDIM - int'(wi) / PARAM_WDIM;
        ox = int'(ii) % PARAM_IDIM - int'(wi) % PARAM_WDIM;
        return (oy >= 0) && (oy < ODIM) && (ox >= 0) && (ox < ODIM);
    endfunction

    function automatic logic [OUT_IW-1:0] out_index(input logic [7:0] ii, input logic [7:0] wi);
        int oy;
        int ox;
        oy = int'(ii) / PARAM_IDIM - int'(wi) / PARAM_WDIM;
        ox = int'(ii) % PARAM_IDIM - int'(wi) % PARAM_WDIM;
        return OUT_IW'(oy * ODIM + ox);
    endfunction

    function automatic logic signed [PARAM_ACC_W-1:0] sext_prod(input logic signed [31:0] p);
        return PARAM_ACC_W'(p);
    endfunction

    assign n_grp_i = num_groups(cnt_ips, PARAM_I);
    assign n_grp_w = num_groups(cnt_wts, PARAM_F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_ips <= '0;
            cnt_wts <= '0;
            grp_i   <= '0;
            grp_w   <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= vld_p0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt_ips <= clamp_cnt(bus.num_nz_ips, PARAM_MAX_NZI);
                        cnt_wts <= clamp_cnt(bus.num_nz_wts, PARAM_MAX_NZW);
                        grp_i   <= '0;
                        grp_w   <= '0;
                        busy_r  <= 1'b1;
                        // An empty job skips issue; the empty pipeline lets DRAIN finish next cycle.
                        state   <= (bus.num_nz_ips == 8'd0 || bus.num_nz_wts == 8'd0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    vld_p0 <= 1'b1;
                    if (grp_w == n_grp_w - 8'd1) begin
                        grp_w <= '0;
                        if (grp_i == n_grp_i - 8'd1) state <= DRAIN;
                        else                         grp_i <= grp_i + 8'd1;
                    end else begin
                        grp_w <= grp_w + 8'd1;
                    end
                end
                DRAIN: begin
                    if (!vld_p0 && !vld_p1) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p0: operand register, lanes beyond the latched counts are flagged off
    always_ff @(posedge clk) begin
        for (int i = 0; i < PARAM_I; i++) begin
            ip_ok_p0[i]  <= (int'(grp_i) * PARAM_I + i) < int'(cnt_ips);
            ip_val_p0[i] <= bus.compressed_inputs[ips_slot(grp_i, i)];
            ip_idx_p0[i] <= bus.comp_indices_ips[ips_slot(grp_i, i)];
        end
        for (int j = 0; j < PARAM_F; j++) begin
            wt_ok_p0[j]  <= (int'(grp_w) * PARAM_F + j) < int'(cnt_wts);
            wt_val_p0[j] <= bus.compressed_weights[wts_slot(grp_w, j)];
            wt_idx_p0[j] <= bus.comp_indices_wts[wts_slot(grp_w, j)];
        end
    end

    // p1: product register with target output coordinate
    always_ff @(posedge clk) begin
        for (int i = 0; i < PARAM_I; i++) begin
            for (int j = 0; j < PARAM_F; j++) begin
                prod_p1[i*PARAM_F+j] <= 32'(ip_val_p0[i]) * 32'(wt_val_p0[j]);
                oidx_p1[i*PARAM_F+j] <= out_index(ip_idx_p0[i], wt_idx_p0[j]);
                ok_p1[i*PARAM_F+j]   <= ip_ok_p0[i] && wt_ok_p0[j] &&
                                        out_hit(ip_idx_p0[i], wt_idx_p0[j]);
            end
        end
    end

    // p2: every output sums all products aimed at it in the same cycle
    always_comb begin
        for (int o = 0; o < NOUT; o++) begin
            grp_sum[o] = '0;
            for (int k = 0; k < NPROD; k++) begin
                if (ok_p1[k] && int'(oidx_p1[k]) == o)
                    grp_sum[o] = grp_sum[o] + sext_prod(prod_p1[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NOUT; o++) acc[o] <= '0;
        end else if (state == IDLE && bus.start && bus.clear_acc) begin
            for (int o = 0; o < NOUT; o++) acc[o] <= '0;
        end else if (vld_p1) begin
            for (int o = 0; o < NOUT; o++) acc[o] <= acc[o] + grp_sum[o];
        end
    end

    assign bus.conv_outputs = acc;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
endmodule

// File: tb/tb_scnn_pe_v2.sv
// Directed bench for scnn_pe_v2 with IDIM=4, WDIM=3, I=F=4 and hand-computed results.
module tb_scnn_pe_v2;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   lat;
    int   dones;

    always #5 clk = ~clk;

    scnn_pe_v2_if #(
        .PARAM_MAX_NZI(16), .PARAM_MAX_NZW(16), .PARAM_IDIM(4), .PARAM_WDIM(3), .PARAM_ACC_W(32)
    ) bus ();

    scnn_pe_v2 #(
        .PARAM_I(4), .PARAM_F(4), .PARAM_MAX_NZI(16), .PARAM_MAX_NZW(16),
        .PARAM_IDIM(4), .PARAM_WDIM(3), .PARAM_ACC_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, "_out0"}, bus.conv_outputs[0], e0);
        check({tag, "_out1"}, bus.conv_outputs[1], e1);
        check({tag, "_out2"}, bus.conv_outputs[2], e2);
        check({tag, "_out3"}, bus.conv_outputs[3], e3);
    endtask

    task automatic zero_bus();
        for (int k = 0; k < 16; k++) begin
            bus.compressed_inputs[k]  = '0;
            bus.comp_indices_ips[k]   = '0;
            bus.compressed_weights[k] = '0;
            bus.comp_indices_wts[k]   = '0;
        end
    endtask

    task automatic load_dense();
        for (int k = 0; k < 16; k++) begin
            bus.compressed_inputs[k] = 16'sd1;
            bus.comp_indices_ips[k]  = 8'(k);
        end
        for (int k = 0; k < 9; k++) begin
            bus.compressed_weights[k] = 16'sd1;
            bus.comp_indices_wts[k]   = 8'(k);
        end
        bus.num_nz_ips = 8'd16;
        bus.num_nz_wts = 8'd9;
    endtask

    task automatic start_job(input logic clr);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.clear_acc = clr;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_job(input string tag, input logic clr, input int exp_lat);
        int n;
        start_job(clr);
        check({tag, "_busy_early"}, bus.busy, 1);
        wait_done(n);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_at_done"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.clear_acc  = 1'b0;
        bus.num_nz_ips = '0;
        bus.num_nz_wts = '0;
        zero_bus();
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check_outs("rst", 0, 0, 0, 0);
        rst = 1'b0;

        // Dense 4x4 input of ones with a 3x3 kernel of ones: every output is 9, G = 4*3.
        load_dense();
        run_job("dense", 1'b1, 15);
        check_outs("dense", 9, 9, 9, 9);

        // Single product; stale dense values in higher slots must stay masked.
        bus.compressed_inputs[0]  = 16'sd3;
        bus.comp_indices_ips[0]   = 8'd5;
        bus.compressed_weights[0] = 16'sd2;
        bus.comp_indices_wts[0]   = 8'd0;
        bus.num_nz_ips = 8'd1;
        bus.num_nz_wts = 8'd1;
        run_job("single", 1'b1, 4);
        check_outs("single", 0, 0, 0, 6);

        run_job("accum", 1'b0, 4);
        check_outs("accum", 0, 0, 0, 12);

        // Two products land on output 0 in the same group.
        zero_bus();
        bus.compressed_inputs[0]  = 16'sd1;
        bus.comp_indices_ips[0]   = 8'd0;
        bus.compressed_inputs[1]  = 16'sd1;
        bus.comp_indices_ips[1]   = 8'd5;
        bus.compressed_weights[0] = 16'sd2;
        bus.comp_indices_wts[0]   = 8'd0;
        bus.compressed_weights[1] = 16'sd5;
        bus.comp_indices_wts[1]   = 8'd4;
        bus.num_nz_ips = 8'd2;
        bus.num_nz_wts = 8'd2;
        run_job("collide", 1'b1, 4);
        check_outs("collide", 7, 0, 0, 2);

        bus.num_nz_ips = 8'd0;
        run_job("zero", 1'b1, 1);
        check_outs("zero", 0, 0, 0, 0);

        // A start pulse while busy must be ignored.
        zero_bus();
        load_dense();
        start_job(1'b1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            bus.start     = (lat == 4);
            bus.clear_acc = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("busystart_latency", lat, 15);
        check_outs("busystart", 9, 9, 9, 9);
        repeat (3) @(negedge clk);
        check("busystart_idle", bus.busy, 0);
        check("busystart_nodone", bus.done, 0);

        // Reset in the middle of a dense job.
        start_job(1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check_outs("midrst", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_idle", bus.busy, 0);

        zero_bus();
        bus.compressed_inputs[0]  = 16'sd3;
        bus.comp_indices_ips[0]   = 8'd5;
        bus.compressed_weights[0] = 16'sd2;
        bus.comp_indices_wts[0]   = 8'd0;
        bus.num_nz_ips = 8'd1;
        bus.num_nz_wts = 8'd1;
        run_job("postrst", 1'b1, 4);
        check_outs("postrst", 0, 0, 0, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
